// File: rtl/decoder_scan_if.sv
// Bundle of control, select and result signals between a decoder_scan instance and its driver.
interface decoder_scan_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 1 << SEL_W;

  logic               en;
  logic               mode;
  logic               in_valid;
  logic [SEL_W-1:0]   in_sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   out;
  logic               out_valid;
  logic               wrap;

  modport master (
    output en, mode, in_valid, in_sel, dwell,
    input  out, out_valid, wrap
  );

  modport slave (
    input  en, mode, in_valid, in_sel, dwell,
    output out, out_valid, wrap
  );
endinterface

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with a self-running scan mode.
// Define DECODER_SCAN_ACTIVE_LOW_EN to drive `out` one-cold instead of one-hot.
module decoder_scan #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input logic          clk,
  input logic          rst,
  decoder_scan_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;

  typedef enum logic {ST_DIRECT, ST_SCAN} state_t;

  state_t             state_q;
  logic [OUT_W-1:0]   onehot_q;
  logic               out_valid_q;
  logic               wrap_q;
  logic [SEL_W-1:0]   idx_q;
  logic [SEL_W-1:0]   idx_d;
  logic [DWELL_W-1:0] cnt_q;
  logic [OUT_W-1:0]   sel_dec;
  logic [OUT_W-1:0]   idx_dec;

  // Index increments modulo OUT_W through natural overflow of SEL_W bits.
  assign idx_d = idx_q + SEL_W'(1);

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
    assign sel_dec[gi] = (bus.in_sel == SEL_W'(gi));
    assign idx_dec[gi] = (idx_d == SEL_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_DIRECT;
      onehot_q    <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else if (!bus.en) begin
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_DIRECT: begin
          wrap_q <= 1'b0;
          if (bus.mode) begin
            state_q     <= ST_SCAN;
            onehot_q    <= OUT_W'(1);
            idx_q       <= '0;
            cnt_q       <= bus.dwell;
            out_valid_q <= 1'b1;
          end else if (bus.in_valid) begin
            onehot_q    <= sel_dec;
            out_valid_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (!bus.mode) begin
            state_q <= ST_DIRECT;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            if (bus.in_valid) begin
              onehot_q    <= sel_dec;
              out_valid_q <= 1'b1;
            end else begin
              out_valid_q <= 1'b0;
            end
          end else begin
            out_valid_q <= 1'b1;
            if (cnt_q != '0) begin
              cnt_q  <= cnt_q - DWELL_W'(1);
              wrap_q <= 1'b0;
            end else begin
              // dwell is picked up only here, so a change lands on the next step
              idx_q    <= idx_d;
              onehot_q <= idx_dec;
              cnt_q    <= bus.dwell;
              wrap_q   <= &idx_q;
            end
          end
        end
        default: state_q <= ST_DIRECT;
      endcase
    end
  end

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  assign bus.out = ~onehot_q;
`else
  assign bus.out = onehot_q;
`endif
  assign bus.out_valid = out_valid_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// Directed, table-driven bench for decoder_scan with SEL_W=3, DWELL_W=8.
module tb_decoder_scan;
  localparam int SEL_W   = 3;
  localparam int DWELL_W = 8;

  typedef struct {
    logic       en;
    logic       mode;
    logic       iv;
    logic [2:0] sel;
    logic [7:0] dwell;
    logic [7:0] exp_out;
    logic       exp_valid;
    logic       exp_wrap;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  decoder_scan_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

  decoder_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] pol(input logic [7:0] x);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  function automatic vec_t mk(input logic en, input logic mode, input logic iv,
                              input logic [2:0] sel, input logic [7:0] dwell,
                              input logic [7:0] eo, input logic ev, input logic ew);
    vec_t v;
    v.en = en; v.mode = mode; v.iv = iv; v.sel = sel; v.dwell = dwell;
    v.exp_out = eo; v.exp_valid = ev; v.exp_wrap = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    bus.en       = v.en;
    bus.mode     = v.mode;
    bus.in_valid = v.iv;
    bus.in_sel   = v.sel;
    bus.dwell    = v.dwell;
    @(posedge clk);
    #1;
    $display("%s en=%b mode=%b iv=%b sel=%0d dwell=%0d -> out=%02h valid=%b wrap=%b",
             tag, v.en, v.mode, v.iv, v.sel, v.dwell, bus.out, bus.out_valid, bus.wrap);
    chk({tag, ".out"}, bus.out, pol(v.exp_out));
    chk({tag, ".valid"}, {7'd0, bus.out_valid}, {7'd0, v.exp_valid});
    chk({tag, ".wrap"}, {7'd0, bus.wrap}, {7'd0, v.exp_wrap});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_sel = '0; bus.dwell = '0;
    @(posedge clk);
    #1;
    chk("reset.out", bus.out, pol(8'h00));
    chk("reset.valid", {7'd0, bus.out_valid}, 8'd0);
    chk("reset.wrap", {7'd0, bus.wrap}, 8'd0);
    rst = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    // Direct decode table: consecutive selects, then idle hold and disabled cycle.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 0, 1, 3'(i), 8'd0, 8'h01 << i, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3'd1, 8'd0, 8'h80, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'd2, 8'd0, 8'h80, 0, 0));
    tbl.push_back(mk(1, 0, 1, 3'd5, 8'd0, 8'h20, 1, 0));

    do_reset();
    foreach (tbl[i]) apply($sformatf("direct[%0d]", i), tbl[i]);

    // Scan sweep with dwell=2: each index held 3 cycles, then wrap back to bit 0.
    do_reset();
    for (int k = 0; k < 24; k++)
      apply($sformatf("scan2[%0d]", k), mk(1, 1, 1, 3'd6, 8'd2, 8'h01 << (k / 3), 1, 0));
    apply("scan2.wrap", mk(1, 1, 0, 3'd0, 8'd2, 8'h01, 1, 1));
    apply("scan2.after", mk(1, 1, 0, 3'd0, 8'd2, 8'h01, 1, 0));

    // Scan with dwell=0 and a 4-cycle enable gap.
    do_reset();
    for (int k = 0; k < 3; k++)
      apply($sformatf("scan0[%0d]", k), mk(1, 1, 0, 3'd0, 8'd0, 8'h01 << k, 1, 0));
    for (int k = 0; k < 4; k++)
      apply($sformatf("gap[%0d]", k), mk(0, 1, 0, 3'd0, 8'd0, 8'h04, 0, 0));
    for (int k = 3; k < 8; k++)
      apply($sformatf("resume[%0d]", k), mk(1, 1, 0, 3'd0, 8'd0, 8'h01 << k, 1, 0));
    apply("resume.wrap", mk(1, 1, 0, 3'd0, 8'd0, 8'h01, 1, 1));
    apply("resume.idx1", mk(1, 1, 0, 3'd0, 8'd0, 8'h02, 1, 0));
    apply("resume.idx2", mk(1, 1, 0, 3'd0, 8'd0, 8'h04, 1, 0));

    // Raise dwell to 5 while at index 2: takes effect on the step to index 3.
    for (int k = 0; k < 6; k++)
      apply($sformatf("dw5.idx3[%0d]", k), mk(1, 1, 1, 3'd7, 8'd5, 8'h08, 1, 0));
    apply("dw5.idx4", mk(1, 1, 0, 3'd0, 8'd5, 8'h10, 1, 0));
    apply("exit.hold", mk(1, 0, 0, 3'd0, 8'd5, 8'h10, 0, 0));
    apply("reenter", mk(1, 1, 0, 3'd0, 8'd5, 8'h01, 1, 0));
    apply("reenter.hold", mk(1, 1, 0, 3'd0, 8'd5, 8'h01, 1, 0));
    apply("exit.decode", mk(1, 0, 1, 3'd6, 8'd5, 8'h40, 1, 0));

    // Reset asserted mid-scan with enable low.
    apply("rscan.enter", mk(1, 1, 0, 3'd0, 8'd1, 8'h01, 1, 0));
    apply("rscan.idx0", mk(1, 1, 0, 3'd0, 8'd1, 8'h01, 1, 0));
    apply("rscan.idx1", mk(1, 1, 0, 3'd0, 8'd1, 8'h02, 1, 0));
    do_reset();
    apply("post.idle", mk(1, 0, 0, 3'd0, 8'd1, 8'h00, 0, 0));
    apply("post.sel3", mk(1, 0, 1, 3'd3, 8'd1, 8'h08, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decoder_scan.md
# decoder_scan

Registered, parametrised binary-to-one-hot decoder with a self-running scan mode. Direct mode decodes a SEL_W-bit select into a 2^SEL_W one-hot word with one-cycle latency. Scan mode walks the one-hot bit across all outputs with a programmable dwell, for row/digit multiplexing. It is the clocked, generalised successor of the fixed 3-to-8 combinational decoder.

## Interface
- SEL_W, 3, select width; must be 1..6
- OUT_W, 2**SEL_W, derived output width; not overridable
- DWELL_W, 8, width of dwell counter and `dwell` input
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  clock enable; 0 freezes all state
- mode  input  1  0 = DIRECT, 1 = SCAN
- in_valid  input  1  DIRECT: `in_sel` valid this cycle
- in_sel  input  SEL_W  DIRECT: index to decode
- dwell  input  DWELL_W  SCAN: extra cycles each index is held (hold time = dwell+1)
- out  output  OUT_W  registered one-hot word
- out_valid  output  1  `out` updated this cycle
- wrap  output  1  one-cycle pulse when scan index returns to 0

## Operation
- Reset (rst=1 at clk edge): out=0, out_valid=0, wrap=0, scan index=0, dwell counter=0, state=DIRECT. rst overrides en.
- States: DIRECT, SCAN. State follows `mode`, sampled each cycle with en=1. mode is ignored while en=0.
- DIRECT, in_valid=1: out <= 1<<in_sel, out_valid <= 1. in_valid=0: out holds, out_valid <= 0. wrap always 0.
- DIRECT->SCAN (mode=1 sampled in DIRECT): out <= bit 0, index=0, dwell counter loaded with `dwell`, out_valid <= 1, wrap <= 0.
- SCAN: out_valid <= 1 every enabled cycle. If counter!=0, decrement, out holds. If counter==0, index <= index+1 (mod OUT_W), out <= 1<<new index, counter <= current `dwell`.
- Wrap: index OUT_W-1 -> 0 sets wrap=1 in the same cycle out shows bit 0. The DIRECT->SCAN entry does not assert wrap.
- `dwell` is sampled only on reload, so changes take effect at the next index step. dwell=0 advances every cycle.
- SCAN->DIRECT (mode=0 sampled in SCAN): out holds, out_valid <= 0 unless in_valid=1 that cycle, in which case decode as normal. Index and counter clear to 0.
- en=0: out, index, counter and state hold. out_valid <= 0, wrap <= 0.
- in_sel and in_valid are ignored in SCAN.
- `out` is never multi-hot. It is all-zero only after reset until the first decode or scan entry.

## Timing
- All outputs registered; no combinational input-to-output path.
- DIRECT latency: 1 cycle from in_valid to out/out_valid.
- SCAN entry: bit 0 visible 1 cycle after mode=1 is sampled.
- Steady SCAN period: each index is held exactly dwell+1 enabled cycles. A full sweep is OUT_W*(dwell+1) enabled cycles.
- Disabled cycles do not count toward dwell.
- wrap pulses once per sweep and lasts 1 cycle.
- Back-to-back in_valid gives one decode per cycle at full throughput.

## Configuration
- DECODER_SCAN_ACTIVE_LOW_EN defined: `out` is driven inverted (one-cold). Reset value is all ones; the selected bit is 0. out_valid and wrap are unaffected.
- Not defined: active-high one-hot as described above. Reset value is all zeros.

## Test plan
- Reset, then DIRECT with in_valid=1 and in_sel=0..7 on consecutive cycles (SEL_W=3) -> out=0x01,0x02,...,0x80 one cycle later each, out_valid=1 throughout. After in_valid drops, out holds 0x80 with out_valid=0.
- SCAN with dwell=2, SEL_W=3 -> out=0x01 for 3 cycles, then 0x02,...,0x80 for 3 cycles each, then 0x01 with wrap=1 for 1 cycle. Sweep period is 24 cycles.
- SCAN with dwell=0, and en toggled low for 4 cycles mid-sweep -> out freezes, out_valid=0 while disabled, index resumes with no skip and no repeat.
- Change dwell from 0 to 5 mid-hold, then switch mode to 0 while at index 4 -> new dwell applies at the next step. out holds 0x10, index clears, and the next mode=1 restarts at 0x01 with wrap=0.
- Assert rst mid-scan with en=0 -> next cycle out=0x00, out_valid=0, wrap=0, state=DIRECT. Rebuild with DECODER_SCAN_ACTIVE_LOW_EN -> reset out=0xFF, and decoding in_sel=3 gives out=0xF7.
